// File: rtl/register_file_8x16_pkg.sv
// Shared widths, types and reset value for the Rechenwerk register file.
package register_file_8x16_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam word_t REG_RST_VAL = '0;

endpackage

// File: rtl/register_file_8x16_if.sv
// Write port plus two read ports of the register file, grouped as one bus.
interface register_file_8x16_if;
  import register_file_8x16_pkg::*;

  word_t     regIn;
  reg_addr_t regInAddr;
  logic      regInWE;
  reg_addr_t regOut1Addr;
  reg_addr_t regOut2Addr;
  word_t     regOut1;
  word_t     regOut2;

  modport master (
    output regIn, regInAddr, regInWE, regOut1Addr, regOut2Addr,
    input  regOut1, regOut2
  );

  modport slave (
    input  regIn, regInAddr, regInWE, regOut1Addr, regOut2Addr,
    output regOut1, regOut2
  );

endinterface

// File: rtl/register_file_8x16_cell.sv
// One DATA_W storage register with async active-low clear and clock enable.
module register_file_8x16_cell
  import register_file_8x16_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_en,
  input  word_t i_d,
  output word_t o_q
);

  word_t r_q;

  // An unknown enable (from an X address) is treated as "no write".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= REG_RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_file_8x16.sv
// 8x16 register file: one synchronous write port, two combinational read ports.
module register_file_8x16
  import register_file_8x16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  register_file_8x16_if.slave  bus
);

  logic [NUM_REGS-1:0] w_we;
  word_t               w_q [NUM_REGS];

  // One-hot write decoder, gated by the write enable.
  always_comb begin
    w_we = '0;
    if (bus.regInWE) begin
      w_we = NUM_REGS'(1) << bus.regInAddr;
    end
  end

  for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_cell
    register_file_8x16_cell u_cell (
      .clk   (clk),
      .rst_n (rst),
      .i_en  (w_we[k]),
      .i_d   (bus.regIn),
      .o_q   (w_q[k])
    );
  end

  // No write-through: reads always see the stored value.
  assign bus.regOut1 = w_q[bus.regOut1Addr];
  assign bus.regOut2 = w_q[bus.regOut2Addr];

endmodule

// File: tb/tb_register_file_8x16.sv
// Scoreboard bench for register_file_8x16 against a behavioural register model.
module tb_register_file_8x16;
  import register_file_8x16_pkg::*;

  logic clk;
  logic rst;
  register_file_8x16_if rf_if ();

  register_file_8x16 dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  word_t model [NUM_REGS];
  word_t exp_q [$];
  int    n_cmp;
  int    n_err;

  task automatic check_eq(input string tag, input word_t obs, input word_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(NUM_REGS); i++) model[i] = REG_RST_VAL;
  endtask

  // Drive read addresses, queue the model's values, then compare after settling.
  task automatic read_pair(input reg_addr_t a1, input reg_addr_t a2, input string tag);
    rf_if.regOut1Addr = a1;
    rf_if.regOut2Addr = a2;
    exp_q.push_back(model[a1]);
    exp_q.push_back(model[a2]);
    #1;
    check_eq($sformatf("%s_p1_a%0d", tag, a1), rf_if.regOut1, exp_q.pop_front());
    check_eq($sformatf("%s_p2_a%0d", tag, a2), rf_if.regOut2, exp_q.pop_front());
  endtask

  task automatic write_reg(input reg_addr_t a, input word_t d);
    @(negedge clk);
    rf_if.regInAddr = a;
    rf_if.regIn     = d;
    rf_if.regInWE   = 1'b1;
    @(posedge clk);
    model[a] = d;
    @(negedge clk);
    rf_if.regInWE   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_model();
    rst               = 1'b0;
    rf_if.regIn       = '0;
    rf_if.regInAddr   = '0;
    rf_if.regInWE     = 1'b0;
    rf_if.regOut1Addr = '0;
    rf_if.regOut2Addr = '0;

    // Reset, with a write attempted while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rf_if.regInAddr = 3'd1;
    rf_if.regIn     = 16'hDEAD;
    rf_if.regInWE   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rf_if.regInWE   = 1'b0;
    read_pair(3'd1, 3'd1, "rst_wr");
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      read_pair(reg_addr_t'(i), reg_addr_t'(i), "rst");
    end

    // Sequential writes.
    write_reg(3'd0, 16'hFFFF);
    write_reg(3'd1, 16'hAAAA);
    write_reg(3'd2, 16'hBBBB);
    write_reg(3'd3, 16'h5555);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      read_pair(reg_addr_t'(i), reg_addr_t'(i), "seq");
    end

    // Write-enable gating.
    @(negedge clk);
    rf_if.regInAddr = 3'd4;
    rf_if.regIn     = 16'h1234;
    rf_if.regInWE   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    read_pair(3'd4, 3'd4, "we_gate");

    // Back-to-back same address: last write wins.
    write_reg(3'd5, 16'h0F0F);
    write_reg(3'd5, 16'hF0F0);
    @(negedge clk);
    read_pair(3'd5, 3'd5, "last_wins");

    // All addresses, dual-port independence.
    for (int k = 0; k < int'(NUM_REGS); k++) write_reg(reg_addr_t'(k), word_t'(16'h1111 * k));
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      @(negedge clk);
      read_pair(reg_addr_t'(k), reg_addr_t'(7 - k), "dual");
    end
    // Model-independent constant spot-checks.
    @(negedge clk);
    rf_if.regOut1Addr = 3'd6;
    rf_if.regOut2Addr = 3'd3;
    #1;
    check_eq("const_r6", rf_if.regOut1, 16'h6666);
    check_eq("const_r3", rf_if.regOut2, 16'h3333);

    // Read-during-write: old value before edge, new after.
    write_reg(3'd2, 16'hBBBB);
    @(negedge clk);
    rf_if.regInAddr   = 3'd2;
    rf_if.regIn       = 16'hCAFE;
    rf_if.regInWE     = 1'b1;
    read_pair(3'd2, 3'd2, "rdw_before");
    check_eq("rdw_before_const", rf_if.regOut1, 16'hBBBB);
    @(posedge clk);
    model[2] = 16'hCAFE;
    #1;
    rf_if.regInWE = 1'b0;
    read_pair(3'd2, 3'd0, "rdw_after");
    check_eq("rdw_after_const", rf_if.regOut1, 16'hCAFE);

    // Async reset between edges.
    write_reg(3'd0, 16'hFFFF);
    @(negedge clk);
    rf_if.regOut1Addr = 3'd0;
    rf_if.regOut2Addr = 3'd0;
    #1;
    check_eq("pre_async", rf_if.regOut1, 16'hFFFF);
    @(posedge clk);
    #3;
    rst = 1'b0;
    clear_model();
    read_pair(3'd0, 3'd7, "async_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      @(negedge clk);
      read_pair(reg_addr_t'(i), reg_addr_t'(7 - i), "post_rst");
    end

    // First write right after reset release.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    write_reg(3'd6, 16'h9ABC);
    @(negedge clk);
    read_pair(3'd6, 3'd5, "first_wr");

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
